// File: rtl/dmem_responder.sv
// Data-memory responder for the LC-3b MEM stage: word SRAM with byte-enable
// writes, fixed access latency and a periodic refresh window that answers with retry.
//   state     | meaning
//   S_IDLE    | sample stb & cyc; start a refresh if one is pending
//   S_WAIT    | access latency countdown; cyc low aborts
//   S_RESP    | response cycle; initiator changes its request here
//   S_REFRESH | refresh window countdown; every request is retried
module dmem_responder #(
  parameter int ADDR_BITS      = 10,
  parameter int LATENCY        = 2,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dmem_address,
  input  logic [15:0] dmem_wdata,
  input  logic        dmem_action_stb,
  input  logic        dmem_action_cyc,
  input  logic        dmem_write,
  input  logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_retry
);

  localparam int DEPTH      = 1 << ADDR_BITS;
  localparam int RW         = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int PERIOD_M1  = (REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0;
  localparam bit REFRESH_EN = (REFRESH_PERIOD != 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_REFRESH} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic [RW-1:0]          ref_cnt;
  logic                   refresh_pending;
  logic                   ref_wrap;
  logic                   request;
  logic [ADDR_BITS-1:0]   idx_q;
  logic                   wr_q;
  logic [15:0]            wdata_q;
  logic [1:0]             be_q;
  logic                   resp_d;
  logic                   retry_d;
  logic [15:0]            rdata_d;
  logic [15:0]            mem [DEPTH];
  logic                   unused_addr;

  assign request     = dmem_action_stb & dmem_action_cyc;
  assign ref_wrap    = REFRESH_EN && (ref_cnt == RW'(PERIOD_M1));
  assign unused_addr = ^{dmem_address[0], dmem_address[15:ADDR_BITS+1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dmem_resp  <= 1'b0;
      dmem_retry <= 1'b0;
      dmem_rdata <= 16'h0000;
    end else begin
      state      <= state_nxt;
      dmem_resp  <= resp_d;
      dmem_retry <= retry_d;
      dmem_rdata <= rdata_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (refresh_pending && REFRESH_EN) state_nxt = S_REFRESH;
        else if (request)                  state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!dmem_action_cyc) state_nxt = S_IDLE;
        else if (cnt == 4'd0) state_nxt = S_RESP;
      end
      S_RESP:    state_nxt = S_IDLE;
      S_REFRESH: if (cnt == 4'd0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered above.
  always_comb begin
    resp_d  = (state == S_WAIT) && dmem_action_cyc && (cnt == 4'd0);
    retry_d = request && ((state == S_REFRESH) ||
                          ((state == S_IDLE) && refresh_pending && REFRESH_EN));
    rdata_d = 16'h0000;
    if (resp_d && !wr_q) rdata_d = mem[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= 4'd0;
      ref_cnt         <= '0;
      refresh_pending <= 1'b0;
      idx_q           <= '0;
      wr_q            <= 1'b0;
      wdata_q         <= 16'h0000;
      be_q            <= 2'b00;
    end else begin
      if (REFRESH_EN) ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      // A wrap during a pending or active refresh merges into it.
      if (ref_wrap)                                   refresh_pending <= 1'b1;
      else if ((state == S_REFRESH) && (cnt == 4'd0)) refresh_pending <= 1'b0;
      case (state)
        S_IDLE: begin
          if (state_nxt == S_WAIT) begin
            cnt     <= 4'(LATENCY - 1);
            idx_q   <= dmem_address[ADDR_BITS:1];
            wr_q    <= dmem_write;
            wdata_q <= dmem_wdata;
            be_q    <= dmem_byte_enable;
          end else if (state_nxt == S_REFRESH) begin
            cnt <= 4'(REFRESH_CYCLES - 1);
          end
        end
        S_WAIT, S_REFRESH: if (cnt != 4'd0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Array is deliberately not reset; a write commits on entry to S_RESP.
  always_ff @(posedge clk) begin
    if (resp_d && wr_q) begin
      if (be_q[0]) mem[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem[idx_q][15:8] <= wdata_q[15:8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with different latency/refresh
// settings, a transaction-timeline reference model and directed literal checks.
module tb_dmem_responder;

  logic        clk;
  logic        rst_a   [4];
  logic [15:0] addr_a  [4];
  logic [15:0] wd_a    [4];
  logic        stb_a   [4];
  logic        cyc_a   [4];
  logic        wr_a    [4];
  logic [1:0]  be_a    [4];
  logic [15:0] rd_a    [4];
  logic        resp_a  [4];
  logic        retry_a [4];

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state: transaction due edges and refresh windows.
  int          now_e      [4];
  bit          tx_on      [4];
  int          tx_due     [4];
  bit          tx_wr      [4];
  logic [9:0]  tx_idx     [4];
  logic [15:0] tx_wd      [4];
  logic [1:0]  tx_be      [4];
  int          rest_until [4];
  bit          rf_on      [4];
  int          rf_end     [4];
  bit          pend       [4];
  bit          exp_resp   [4];
  bit          exp_retry  [4];
  bit          exp_wr     [4];
  logic [15:0] exp_rd     [4];
  logic [15:0] exp_mask   [4];
  logic [15:0] mm [4][1024];
  logic [1:0]  mk [4][1024];

  dmem_responder #(.ADDR_BITS(10), .LATENCY(2), .REFRESH_PERIOD(0), .REFRESH_CYCLES(4)) u0 (
    .clk(clk), .rst_n(rst_a[0]), .dmem_address(addr_a[0]), .dmem_wdata(wd_a[0]),
    .dmem_action_stb(stb_a[0]), .dmem_action_cyc(cyc_a[0]), .dmem_write(wr_a[0]),
    .dmem_byte_enable(be_a[0]), .dmem_rdata(rd_a[0]), .dmem_resp(resp_a[0]), .dmem_retry(retry_a[0]));
  dmem_responder #(.ADDR_BITS(10), .LATENCY(1), .REFRESH_PERIOD(16), .REFRESH_CYCLES(4)) u1 (
    .clk(clk), .rst_n(rst_a[1]), .dmem_address(addr_a[1]), .dmem_wdata(wd_a[1]),
    .dmem_action_stb(stb_a[1]), .dmem_action_cyc(cyc_a[1]), .dmem_write(wr_a[1]),
    .dmem_byte_enable(be_a[1]), .dmem_rdata(rd_a[1]), .dmem_resp(resp_a[1]), .dmem_retry(retry_a[1]));
  dmem_responder #(.ADDR_BITS(10), .LATENCY(5), .REFRESH_PERIOD(16), .REFRESH_CYCLES(4)) u2 (
    .clk(clk), .rst_n(rst_a[2]), .dmem_address(addr_a[2]), .dmem_wdata(wd_a[2]),
    .dmem_action_stb(stb_a[2]), .dmem_action_cyc(cyc_a[2]), .dmem_write(wr_a[2]),
    .dmem_byte_enable(be_a[2]), .dmem_rdata(rd_a[2]), .dmem_resp(resp_a[2]), .dmem_retry(retry_a[2]));
  dmem_responder #(.ADDR_BITS(10), .LATENCY(4), .REFRESH_PERIOD(0), .REFRESH_CYCLES(4)) u3 (
    .clk(clk), .rst_n(rst_a[3]), .dmem_address(addr_a[3]), .dmem_wdata(wd_a[3]),
    .dmem_action_stb(stb_a[3]), .dmem_action_cyc(cyc_a[3]), .dmem_write(wr_a[3]),
    .dmem_byte_enable(be_a[3]), .dmem_rdata(rd_a[3]), .dmem_resp(resp_a[3]), .dmem_retry(retry_a[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 5;
      default: return 4;
    endcase
  endfunction

  function automatic int per_of(input int k);
    return (k == 1 || k == 2) ? 16 : 0;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s[u%0d] at %0t: got %h, want %h", nm, k, $time, act, exp);
    end
  endtask

  // One rising edge of the reference: what the responder must show after it.
  task automatic step(input int k);
    bit         req;
    int         e;
    logic [9:0] ix;
    if (!rst_a[k]) begin
      now_e[k] = 0; tx_on[k] = 0; rf_on[k] = 0; pend[k] = 0; rest_until[k] = 0;
      exp_resp[k] = 0; exp_retry[k] = 0;
      return;
    end
    now_e[k]++;
    e   = now_e[k];
    req = stb_a[k] && cyc_a[k];
    exp_resp[k]  = 0;
    exp_retry[k] = 0;
    if (tx_on[k]) begin
      if (!cyc_a[k]) tx_on[k] = 0;
      else if (e == tx_due[k]) begin
        tx_on[k] = 0; exp_resp[k] = 1; exp_wr[k] = tx_wr[k]; rest_until[k] = e + 1;
        ix = tx_idx[k];
        if (tx_wr[k]) begin
          if (tx_be[k][0]) begin mm[k][ix][7:0]  = tx_wd[k][7:0];  mk[k][ix][0] = 1'b1; end
          if (tx_be[k][1]) begin mm[k][ix][15:8] = tx_wd[k][15:8]; mk[k][ix][1] = 1'b1; end
        end else begin
          exp_rd[k]   = mm[k][ix];
          exp_mask[k] = {{8{mk[k][ix][1]}}, {8{mk[k][ix][0]}}};
        end
      end
    end else if (e > rest_until[k]) begin
      if (rf_on[k]) begin
        exp_retry[k] = req;
        if (e == rf_end[k]) begin rf_on[k] = 0; pend[k] = 0; end
      end else if (pend[k]) begin
        rf_on[k] = 1; rf_end[k] = e + 4; exp_retry[k] = req;
      end else if (req) begin
        tx_on[k] = 1; tx_due[k] = e + lat_of(k); tx_wr[k] = wr_a[k];
        tx_idx[k] = addr_a[k][10:1]; tx_wd[k] = wd_a[k]; tx_be[k] = be_a[k];
      end
    end
    if (per_of(k) != 0 && (e % per_of(k)) == 0) pend[k] = 1;
  endtask

  always @(posedge clk) for (int k = 0; k < 4; k++) step(k);

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_a[k]) begin
        chk("rst_resp", k, resp_a[k], 0);
        chk("rst_retry", k, retry_a[k], 0);
        chk("rst_rdata", k, rd_a[k], 0);
      end else begin
        chk("resp", k, resp_a[k], exp_resp[k]);
        chk("retry", k, retry_a[k], exp_retry[k]);
        if (exp_resp[k]) begin
          if (exp_wr[k]) chk("wr_rdata", k, rd_a[k], 0);
          else if (exp_mask[k] != 16'h0)
            chk("rdata", k, 32'(rd_a[k] & exp_mask[k]), 32'(exp_rd[k] & exp_mask[k]));
        end
      end
    end
  end

  // Called at a falling edge; returns at a falling edge with the bus idle for one edge.
  task automatic do_req(input int k, input bit wr, input logic [15:0] adr, input logic [15:0] dat,
                        input logic [1:0] be, input bit may_abort,
                        output bit got, output logic [15:0] rd, output int lat, output int nret);
    int acc;
    bit fin;
    got = 0; rd = '0; lat = -1; nret = 0; acc = 0; fin = 0;
    wr_a[k] = wr; addr_a[k] = adr; wd_a[k] = dat; be_a[k] = be;
    stb_a[k] = 1'b1; cyc_a[k] = 1'b1;
    for (int i = 0; i < 64 && !fin; i++) begin
      @(negedge clk);
      if (resp_a[k]) begin got = 1; rd = rd_a[k]; lat = i - acc; fin = 1; end
      else if (retry_a[k]) begin nret++; acc = i + 1; end
      else if (may_abort && $urandom_range(0, 7) == 0) fin = 1;
    end
    chk("req_done", k, 32'(fin), 1);
    stb_a[k] = 1'b0; cyc_a[k] = 1'b0;
    @(negedge clk);
    if (got) chk("resp_pulse", k, resp_a[k], 0);
  endtask

  task automatic rand_traffic(input int k, input int n);
    bit got; logic [15:0] rd; int lat, nr;
    for (int t = 0; t < n; t++) begin
      do_req(k, 1'($urandom), {5'($urandom), 6'd0, 4'($urandom), 1'($urandom)},
             16'($urandom), 2'($urandom), 1'b1, got, rd, lat, nr);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic seq0();
    bit got; logic [15:0] rd; int lat, nr;
    do_req(0, 1, 16'h0040, 16'hBEEF, 2'b11, 0, got, rd, lat, nr);
    chk("raw_wr_lat", 0, lat, 2);
    do_req(0, 0, 16'h0041, 16'h0000, 2'b11, 0, got, rd, lat, nr);
    chk("raw_rd_lat", 0, lat, 2);
    chk("raw_rd_data", 0, rd, 16'hBEEF);
    do_req(0, 1, 16'h0040, 16'h1234, 2'b01, 0, got, rd, lat, nr);
    do_req(0, 0, 16'h0040, 16'h0000, 2'b00, 0, got, rd, lat, nr);
    chk("be01_data", 0, rd, 16'hBE34);
    do_req(0, 1, 16'h0040, 16'h5600, 2'b10, 0, got, rd, lat, nr);
    do_req(0, 0, 16'h0040, 16'h0000, 2'b00, 0, got, rd, lat, nr);
    chk("be10_data", 0, rd, 16'h5634);
    do_req(0, 1, 16'h0040, 16'hFFFF, 2'b00, 0, got, rd, lat, nr);
    chk("be00_resp", 0, 32'(got), 1);
    do_req(0, 0, 16'h0040, 16'h0000, 2'b00, 0, got, rd, lat, nr);
    chk("be00_data", 0, rd, 16'h5634);
    rand_traffic(0, 120);
    // Reset while a read response is on the bus must clear it at once.
    wr_a[0] = 0; addr_a[0] = 16'h0040; stb_a[0] = 1; cyc_a[0] = 1;
    for (int i = 0; i < 10 && !resp_a[0]; i++) @(negedge clk);
    chk("pre_rst_resp", 0, resp_a[0], 1);
    chk("pre_rst_data", 0, rd_a[0], 16'h5634);
    #2 rst_a[0] = 0;
    #1 chk("async_resp", 0, resp_a[0], 0);
    chk("async_rdata", 0, rd_a[0], 0);
    stb_a[0] = 0; cyc_a[0] = 0;
    repeat (2) @(negedge clk);
    rst_a[0] = 1;
    do_req(0, 0, 16'h0040, 16'h0000, 2'b00, 0, got, rd, lat, nr);
    chk("mem_kept", 0, rd, 16'h5634);
  endtask

  task automatic seq1();
    bit got; logic [15:0] rd; int lat, nr;
    do_req(1, 1, 16'h0020, 16'h1357, 2'b11, 0, got, rd, lat, nr);
    chk("l1_wr_lat", 1, lat, 1);
    do_req(1, 0, 16'h0020, 16'h0000, 2'b11, 0, got, rd, lat, nr);
    chk("l1_rd_lat", 1, lat, 1);
    chk("l1_rd_data", 1, rd, 16'h1357);
    chk("l1_no_retry", 1, nr, 0);
    for (int i = 0; i < 40 && now_e[1] < 16; i++) @(negedge clk);
    chk("refresh_align", 1, now_e[1], 16);
    do_req(1, 0, 16'h0020, 16'h0000, 2'b11, 0, got, rd, lat, nr);
    chk("refresh_retries", 1, nr, 5);
    chk("refresh_after_lat", 1, lat, 1);
    chk("refresh_after_data", 1, rd, 16'h1357);
    rand_traffic(1, 120);
  endtask

  task automatic seq2();
    bit got; logic [15:0] rd; int lat, nr;
    do_req(2, 1, 16'h0020, 16'h2468, 2'b11, 0, got, rd, lat, nr);
    chk("l5_wr_lat", 2, lat, 5);
    do_req(2, 0, 16'h0020, 16'h0000, 2'b11, 0, got, rd, lat, nr);
    chk("l5_rd_lat", 2, lat, 5);
    chk("l5_rd_data", 2, rd, 16'h2468);
    chk("l5_no_retry", 2, nr, 0);
    rand_traffic(2, 120);
  endtask

  task automatic seq3();
    bit got; logic [15:0] rd; int lat, nr, nresp;
    do_req(3, 1, 16'h0010, 16'h1111, 2'b11, 0, got, rd, lat, nr);
    wr_a[3] = 0; addr_a[3] = 16'h0010; stb_a[3] = 1; cyc_a[3] = 1;
    repeat (2) @(negedge clk);
    chk("abort_rd_early", 3, resp_a[3], 0);
    stb_a[3] = 0; cyc_a[3] = 0;
    nresp = 0;
    repeat (6) begin @(negedge clk); if (resp_a[3]) nresp++; end
    chk("abort_rd_noresp", 3, nresp, 0);
    wr_a[3] = 1; wd_a[3] = 16'h2222; be_a[3] = 2'b11; stb_a[3] = 1; cyc_a[3] = 1;
    repeat (2) @(negedge clk);
    stb_a[3] = 0; cyc_a[3] = 0;
    nresp = 0;
    repeat (6) begin @(negedge clk); if (resp_a[3]) nresp++; end
    chk("abort_wr_noresp", 3, nresp, 0);
    do_req(3, 0, 16'h0010, 16'h0000, 2'b11, 0, got, rd, lat, nr);
    chk("abort_wr_mem", 3, rd, 16'h1111);
    wr_a[3] = 1; wd_a[3] = 16'hAAAA; be_a[3] = 2'b11; stb_a[3] = 1; cyc_a[3] = 1;
    @(negedge clk);
    @(posedge clk);
    #2 rst_a[3] = 0;
    #1 chk("rst_wait_resp", 3, resp_a[3], 0);
    chk("rst_wait_retry", 3, retry_a[3], 0);
    stb_a[3] = 0; cyc_a[3] = 0;
    repeat (2) @(negedge clk);
    rst_a[3] = 1;
    do_req(3, 0, 16'h0010, 16'h0000, 2'b11, 0, got, rd, lat, nr);
    chk("rst_accept", 3, 32'(got), 1);
    chk("rst_wr_dropped", 3, rd, 16'h1111);
    rand_traffic(3, 100);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst_a[k] = 0; stb_a[k] = 0; cyc_a[k] = 0; wr_a[k] = 0;
      addr_a[k] = '0; wd_a[k] = '0; be_a[k] = '0;
      exp_resp[k] = 0; exp_retry[k] = 0; exp_wr[k] = 0; exp_rd[k] = '0; exp_mask[k] = '0;
      for (int j = 0; j < 1024; j++) mk[k][j] = 2'b00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) rst_a[k] = 1;
    fork
      seq0();
      seq1();
      seq2();
      seq3();
    join
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
